// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - state_e   : 2-bit FSM encoding (ST_IDLE=0, ST_CALC=1, ST_DONE=2)
//   - cnt_width : width of the iteration counter for a given operand width
// Optional build macro used by the importing modules: SEQ_MUL_EARLY_TERM_EN
// -----------------------------------------------------------------------------
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH (value after the final step).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// -----------------------------------------------------------------------------
// seq_mul_dp
// Datapath of the shift-and-add multiplier: multiplicand / multiplier shift
// registers, accumulator adder and iteration counter.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active high (clears all registers)
//   load_i    latch a/b, clear accumulator and counter
//   step_i    perform one shift-and-add iteration
//   a_i, b_i  operands (WIDTH bits)
//   last_o    the current step is the final one
//   acc_sum_o accumulator value after the current step (2*WIDTH bits)
// Build macro: SEQ_MUL_EARLY_TERM_EN -- when defined, last_o also asserts as
// soon as the remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   acc_sum_o
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_sum_s;
  logic [WIDTH-1:0] mplier_shr_s;
  logic             last_s;

  // Next-state for the datapath registers and the final-step detection.
  always_comb begin
    acc_sum_s    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shr_s = mplier_q >> 1;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_shr_s;
      acc_d    = acc_sum_s;
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
    end
`ifdef SEQ_MUL_EARLY_TERM_EN
    // Once no set multiplier bits remain, later iterations cannot change acc.
    last_s = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shr_s == '0);
`else
    last_s = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  // Datapath register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o    = last_s;
  assign acc_sum_o = acc_sum_s;

endmodule

// File: rtl/seq_shift_add_mul.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mul
// Parametrised sequential unsigned multiplier, z = a * b, computed by a
// shift-and-add datapath (seq_mul_dp) under a start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active high; aborts any operation, clears z
//   start  request, accepted when the block is IDLE or DONE
//   a, b   operands (WIDTH bits), latched on acceptance
//   busy   high while calculating
//   done   one-cycle completion pulse
//   z      last completed product (2*WIDTH bits), held until next completion
// Build macro: SEQ_MUL_EARLY_TERM_EN (early termination when the remaining
// multiplier bits are zero; results are identical, only latency changes).
// -----------------------------------------------------------------------------
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   z_q, z_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_s, step_s;
  logic                 last_s;
  logic [2*WIDTH-1:0]   acc_sum_s;

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_s),
    .step_i    (step_s),
    .a_i       (a),
    .b_i       (b),
    .last_o    (last_s),
    .acc_sum_o (acc_sum_s)
  );

  // FSM next-state, datapath control and next values of the output registers.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        step_s = 1'b1;
        if (last_s) begin
          // z only ever sees the finished product, never a partial sum.
          z_d     = acc_sum_s;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_s  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;

endmodule
